// File: rtl/sd_boot_pkg.sv
// Shared types and default constants for the SD-card boot sequencer.
package sd_boot_pkg;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DONE,
      WRITE,
      NEXT,
      WAIT_LOW,
      FINISH,
      ERROR
   } boot_state_t;

   localparam int unsigned DEF_TIMEOUT    = 1 << 20;
   localparam int unsigned DEF_NEXT_PULSE = 2;
   localparam int unsigned DEF_WORD_STEP  = 4;

endpackage

// File: rtl/sd_boot_timer.sv
// Clearable up-counter; tc flags when the count equals last_val.
module sd_boot_timer #(
   parameter int unsigned W = 21
) (
   input  logic         control_clk_i,
   input  logic         control_rst_i,
   input  logic         clr,
   input  logic [W-1:0] last_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge control_clk_i) begin
      if (!control_rst_i) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else begin
         count <= count + W'(1);
      end
   end

   assign tc = (count == last_val);

endmodule

// File: rtl/sd_boot_loader.sv
// Fetches BOOT_WORDS words from the SPI microSD controller into instruction
// memory, accumulates a checksum, then releases the CPU from reset.
//
// state     | meaning
// IDLE      | index/address/sum held at start values, wait for boot_start_i
// REQ       | one cycle, raise read enable, clear timer
// WAIT_DONE | wait for sd_done_i, timeout -> ERROR
// WRITE     | one-cycle memory write, accumulate sum
// NEXT      | NEXT_PULSE cycles of sd_nextoper_o
// WAIT_LOW  | wait for sd_done_i to drop, timeout -> ERROR
// FINISH    | image loaded, CPU released, sticky until reset
// ERROR     | handshake stalled, sticky until boot_start_i retries
module sd_boot_loader
   import sd_boot_pkg::*;
#(
   parameter logic [31:0] SD_BASE    = 32'h0000_0000,
   parameter int unsigned WORD_STEP  = DEF_WORD_STEP,
   parameter int unsigned BOOT_WORDS = 256,
   parameter int unsigned MEM_AW     = 10,
   parameter int unsigned NEXT_PULSE = DEF_NEXT_PULSE,
   parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
   input  logic              control_clk_i,
   input  logic              control_rst_i,
   input  logic              boot_start_i,
   input  logic              sd_done_i,
   input  logic [31:0]       sd_data_i,
   output logic [31:0]       sd_address_o,
   output logic              sd_re_o,
   output logic              sd_we_o,
   output logic              sd_nextoper_o,
   output logic              mem_we_o,
   output logic [MEM_AW-1:0] mem_addr_o,
   output logic [31:0]       mem_data_o,
   output logic              cpu_rst_n_o,
   output logic              boot_busy_o,
   output logic              boot_done_o,
   output logic              boot_err_o,
   output logic [31:0]       boot_sum_o
);

   // One timer serves both the handshake timeout and the pulse width.
   localparam int unsigned TW = $clog2((TIMEOUT > NEXT_PULSE) ? TIMEOUT : NEXT_PULSE) + 1;
   localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]     NP_LAST  = TW'(NEXT_PULSE - 1);
   localparam logic [MEM_AW-1:0] LAST_IDX = MEM_AW'(BOOT_WORDS - 1);

   boot_state_t       state, state_next;
   logic              timer_clr, timer_tc;
   logic [TW-1:0]     timer_last;
   logic [MEM_AW-1:0] idx_q;
   logic              busy_d, we_d, next_d, done_d, err_d;

   assign timer_clr  = (state_next != state);
   assign timer_last = (state == NEXT) ? NP_LAST : TO_LAST;

   sd_boot_timer #(.W(TW)) u_timer (
      .control_clk_i (control_clk_i),
      .control_rst_i (control_rst_i),
      .clr           (timer_clr),
      .last_val      (timer_last),
      .tc            (timer_tc)
   );

   always_ff @(posedge control_clk_i) begin
      if (!control_rst_i) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (boot_start_i) state_next = REQ;
         REQ:       state_next = WAIT_DONE;
         WAIT_DONE: begin
            if (sd_done_i)     state_next = WRITE;
            else if (timer_tc) state_next = ERROR;
         end
         WRITE:     state_next = (idx_q == LAST_IDX) ? FINISH : NEXT;
         NEXT:      if (timer_tc) state_next = WAIT_LOW;
         WAIT_LOW: begin
            if (!sd_done_i)    state_next = WAIT_DONE;
            else if (timer_tc) state_next = ERROR;
         end
         FINISH:    state_next = FINISH;
         ERROR:     if (boot_start_i) state_next = REQ;
         default:   state_next = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      busy_d = 1'b0;
      we_d   = 1'b0;
      next_d = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
      case (state_next)
         REQ, WAIT_DONE, WAIT_LOW: busy_d = 1'b1;
         WRITE: begin
            busy_d = 1'b1;
            we_d   = 1'b1;
         end
         NEXT: begin
            busy_d = 1'b1;
            next_d = 1'b1;
         end
         FINISH:  done_d = 1'b1;
         ERROR:   err_d  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge control_clk_i) begin
      if (!control_rst_i) begin
         sd_re_o       <= 1'b0;
         boot_busy_o   <= 1'b0;
         mem_we_o      <= 1'b0;
         sd_nextoper_o <= 1'b0;
         boot_done_o   <= 1'b0;
         cpu_rst_n_o   <= 1'b0;
         boot_err_o    <= 1'b0;
      end else begin
         sd_re_o       <= busy_d;
         boot_busy_o   <= busy_d;
         mem_we_o      <= we_d;
         sd_nextoper_o <= next_d;
         boot_done_o   <= done_d;
         cpu_rst_n_o   <= done_d;
         boot_err_o    <= err_d;
      end
   end

   always_ff @(posedge control_clk_i) begin
      if (!control_rst_i) begin
         idx_q        <= '0;
         sd_address_o <= SD_BASE;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         boot_sum_o   <= '0;
      end else begin
         if (state == IDLE || (state == ERROR && boot_start_i)) begin
            idx_q        <= '0;
            sd_address_o <= SD_BASE;
            boot_sum_o   <= '0;
         end
         if (state == WAIT_DONE && sd_done_i) begin
            mem_addr_o <= idx_q;
            mem_data_o <= sd_data_i;
         end
         // Index and SD address advance on entry to NEXT; the last word has none.
         if (state == WRITE) begin
            boot_sum_o <= boot_sum_o + mem_data_o;
            if (idx_q != LAST_IDX) begin
               idx_q        <= idx_q + MEM_AW'(1);
               sd_address_o <= sd_address_o + 32'(WORD_STEP);
            end
         end
      end
   end

   assign sd_we_o = 1'b0;

endmodule

// File: doc/sd_boot_loader.md
# sd_boot_loader

Boot sequencer sitting directly downstream of the SPI microSD controller (`controlmicro_sd`). It drives the controller's address, read-enable and next-operation inputs to fetch `BOOT_WORDS` consecutive 32-bit words. Each returned word is written into the processor's instruction memory, and a running checksum is accumulated. When the image is complete the block releases the CPU from reset; a stalled card produces a sticky error instead.

## Interface
Parameters:
- `SD_BASE`, 32'h0000_0000, SD byte address of the first boot word.
- `WORD_STEP`, 4, SD address increment per word.
- `BOOT_WORDS`, 256, number of words to load (≥1).
- `MEM_AW`, 10, instruction-memory word-address width; `BOOT_WORDS` ≤ 2^`MEM_AW`.
- `NEXT_PULSE`, 2, width in cycles of the `sd_nextoper_o` pulse.
- `TIMEOUT`, 2^20, maximum wait cycles per handshake phase.

Ports:
- `control_clk_i`  in  1  single clock.
- `control_rst_i`  in  1  reset, synchronous, active-low.
- `boot_start_i`  in  1  start or retry request, sampled in IDLE/ERROR.
- `sd_done_i`  in  1  controller `control_done_o`; level, word valid.
- `sd_data_i`  in  32  controller `mem_data_o`.
- `sd_address_o`  out  32  to controller `sd_address_i`.
- `sd_re_o`  out  1  to `control_re_i`.
- `sd_we_o`  out  1  to `control_we_i`; constant 0.
- `sd_nextoper_o`  out  1  to `control_nextoper_i`.
- `mem_we_o`  out  1  instruction-memory write strobe.
- `mem_addr_o`  out  `MEM_AW`  word address.
- `mem_data_o`  out  32  write data.
- `cpu_rst_n_o`  out  1  CPU reset, active-low.
- `boot_busy_o`, `boot_done_o`, `boot_err_o`  out  1 each  status.
- `boot_sum_o`  out  32  modulo-2^32 sum of the words written.

## Operation
- **IDLE**
  - Holds index=0, `sd_address_o`=`SD_BASE`, sum=0.
  - `boot_start_i`=1 → REQ.
- **REQ** (1 cycle)
  - Sets `sd_re_o`=1. It stays 1 through every state until FINISH or ERROR.
  - Clears the timer → WAIT_DONE.
- **WAIT_DONE**
  - Timer increments each cycle.
  - `sd_done_i`=1 → capture `sd_data_i` → WRITE.
  - Otherwise, timer==`TIMEOUT`-1 → ERROR.
- **WRITE** (1 cycle)
  - `mem_we_o`=1, `mem_addr_o`=index, `mem_data_o`=captured word.
  - sum += word.
  - index==`BOOT_WORDS`-1 → FINISH, else → NEXT.
- **NEXT** (`NEXT_PULSE` cycles)
  - `sd_nextoper_o`=1.
  - On the first cycle: index+1, `sd_address_o` += `WORD_STEP` (32-bit wrap allowed).
  - Then → WAIT_LOW with the timer cleared.
- **WAIT_LOW**
  - Waits for `sd_done_i`=0 → WAIT_DONE with the timer cleared.
  - Timer expiry → ERROR.
- **FINISH** (sticky until reset)
  - `boot_done_o`=1, `cpu_rst_n_o`=1, `sd_re_o`=0.
  - `boot_start_i` is ignored.
  - The last word issues no next-operation pulse.
- **ERROR** (sticky)
  - `boot_err_o`=1, `sd_re_o`=0, `cpu_rst_n_o` stays 0.
  - `boot_start_i`=1 → clear error and all counters → REQ (full retry from `SD_BASE`).
- `boot_busy_o`=1 in REQ, WAIT_DONE, WRITE, NEXT and WAIT_LOW.

## Timing
- All outputs are registered.
- Reset values:
  - All 1-bit outputs 0 (so `cpu_rst_n_o`=0).
  - `sd_address_o`=`SD_BASE`.
  - `mem_addr_o`=0, `mem_data_o`=0, `boot_sum_o`=0.
  - State IDLE.
- Reset applied mid-load aborts immediately. No partial `mem_we_o` after the reset edge.
- `boot_start_i` high at edge t → `sd_re_o`=1 from t+1.
- `sd_done_i` sampled high at edge t → `mem_we_o` high for exactly cycle t+1. `sd_nextoper_o` high from t+2 through t+1+`NEXT_PULSE`.
- `boot_sum_o` includes word n from the edge that ends WRITE.
- `sd_done_i` already 0 when WAIT_LOW is entered → WAIT_DONE the next cycle.
- Timeout is checked per phase; the controller's power-up init (~16k cycles) must fit within `TIMEOUT`.

## Structure
- Shared package `sd_boot_pkg` holds:
  - the state enum (IDLE, REQ, WAIT_DONE, WRITE, NEXT, WAIT_LOW, FINISH, ERROR);
  - default constants for `TIMEOUT`, `NEXT_PULSE` and `WORD_STEP`.
- One sub-module, `sd_boot_timer`: a clearable up-counter with a terminal-count flag.
  - Used for both the handshake timeout and the `NEXT_PULSE` count.

## Test plan
- **Nominal load.** `BOOT_WORDS`=4, `SD_BASE`=32'h0000_1000. Model returns 32'h11111111 … 32'h44444444 at addresses 0x1000/0x1004/0x1008/0x100C.
  - Required: 4 `mem_we_o` strobes at addresses 0–3, `boot_sum_o`=32'hAAAAAAAA.
  - Required: `cpu_rst_n_o` rises after the 4th write; exactly 3 `sd_nextoper_o` pulses, each 2 cycles.
- **Latency.** `sd_done_i` rises at edge t.
  - Required: `mem_we_o` high only in cycle t+1; `sd_nextoper_o` high in t+2 and t+3.
- **Done held high.** Model holds `sd_done_i` for 10 cycles after the pulse.
  - Required: no second write until it drops and rises again.
- **Timeout and retry.** `TIMEOUT`=64, `sd_done_i` never asserts.
  - Required: `boot_err_o`=1 after 64 wait cycles, `sd_re_o`=0.
  - Then `boot_start_i` pulse → reload from 0x1000 succeeds.
- **Reset mid-load.** `control_rst_i`=0 during the 2nd WRITE.
  - Required: all outputs at reset values the next cycle; no further writes.
- **Address wrap.** `SD_BASE`=32'hFFFF_FFFC, `BOOT_WORDS`=2.
  - Required: the second `sd_address_o`=32'h0000_0000.
